// File: rtl/sensor_seq_if.sv
// sensor_seq_if: sequence-table read port and SPI register-write handshake between the controller and its peers.
interface sensor_seq_if #(parameter int TBL_AW = 8);
    logic [TBL_AW-1:0] tbl_addr;
    logic [25:0]       tbl_data;
    logic              spi_valid;
    logic [8:0]        spi_addr;
    logic [15:0]       spi_wdata;
    logic              spi_ready;
    modport master (output tbl_addr, spi_valid, spi_addr, spi_wdata, input tbl_data, spi_ready);
    modport slave  (input tbl_addr, spi_valid, spi_addr, spi_wdata, output tbl_data, spi_ready);
endinterface

// File: rtl/sensor_seq_ctl.sv
// sensor_seq_ctl: sensor power-up/down sequencer replaying register tables over SPI.
// Define SENSOR_SEQ_TIMEOUT_EN to bound the wait for pwr_ready with TIMEOUT_CYCLES.
module sensor_seq_ctl #(
    parameter int TBL_AW         = 8,
    parameter int UP_BASE        = 0,
    parameter int DN_BASE        = 128,
    parameter int SETTLE_CYCLES  = 7200,
    parameter int TIMEOUT_CYCLES = 720000
) (
    input  logic               clk72,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    output logic               pwr_enable,
    input  logic               pwr_ready,
    sensor_seq_if.master       bus,
    output logic               sensor_active,
    output logic               busy,
    output logic               seq_error,
    output logic [3:0]         state
);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    typedef enum logic [3:0] {IDLE, PWR_UP, SETTLE, UP_FETCH, UP_ISSUE, ACTIVE,
                              DN_FETCH, DN_ISSUE, PWR_DN, ERROR} st_t;
    st_t               state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ph_q, ph_d, stop_pend_q, stop_pend_d;
    logic [TBL_AW-1:0] tbl_addr_q, tbl_addr_d;
    logic              spi_valid_q, spi_valid_d;
    logic [8:0]        spi_addr_q, spi_addr_d;
    logic [15:0]       spi_wdata_q, spi_wdata_d;
    logic              pwr_enable_q, sensor_active_q, busy_q, seq_error_q;
    logic              is_up, stop_eff, tmo_hit;
`ifdef SENSOR_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    always_comb begin
        tmo_d   = (state_q == PWR_UP) ? tmo_q + TW'(1) : '0;
        tmo_hit = (state_q == PWR_UP) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    end
    always_ff @(posedge clk72 or posedge reset)
        if (reset) tmo_q <= '0;
        else tmo_q <= tmo_d;
`else
    assign tmo_hit = 1'b0;
`endif
    assign is_up    = (state_q == UP_FETCH) || (state_q == UP_ISSUE);
    assign stop_eff = stop || stop_pend_q;
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ph_d        = 1'b0;
        tbl_addr_d  = tbl_addr_q;
        spi_valid_d = 1'b0;
        spi_addr_d  = spi_addr_q;
        spi_wdata_d = spi_wdata_q;
        case (state_q)
            IDLE, ERROR: if (start && !stop) state_d = PWR_UP;
            PWR_UP: begin
                if (stop) state_d = PWR_DN;
                else if (pwr_ready) begin
                    state_d = SETTLE;
                    cnt_d   = CW'(SETTLE_CYCLES - 1);
                end else if (tmo_hit) state_d = ERROR;
            end
            SETTLE: begin
                if (stop) state_d = PWR_DN;
                else if (cnt_q == '0) begin
                    state_d    = UP_FETCH;
                    tbl_addr_d = TBL_AW'(UP_BASE);
                end else cnt_d = cnt_q - CW'(1);
            end
            // second fetch cycle: tbl_data now reflects tbl_addr_q
            UP_FETCH, DN_FETCH: begin
                ph_d = !ph_q;
                if (ph_q) begin
                    if (is_up && stop_eff) begin
                        state_d    = DN_FETCH;
                        tbl_addr_d = TBL_AW'(DN_BASE);
                    end else if (bus.tbl_data[25]) state_d = is_up ? ACTIVE : PWR_DN;
                    else begin
                        state_d     = is_up ? UP_ISSUE : DN_ISSUE;
                        spi_valid_d = 1'b1;
                        spi_addr_d  = bus.tbl_data[24:16];
                        spi_wdata_d = bus.tbl_data[15:0];
                    end
                end
            end
            UP_ISSUE, DN_ISSUE: begin
                spi_valid_d = !bus.spi_ready;
                if (bus.spi_ready) begin
                    if (is_up && stop_eff) begin
                        state_d    = DN_FETCH;
                        tbl_addr_d = TBL_AW'(DN_BASE);
                    end else begin
                        state_d    = is_up ? UP_FETCH : DN_FETCH;
                        tbl_addr_d = tbl_addr_q + TBL_AW'(1);
                    end
                end
            end
            ACTIVE: if (stop) begin
                state_d    = DN_FETCH;
                tbl_addr_d = TBL_AW'(DN_BASE);
            end
            PWR_DN: if (!pwr_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // losing power while powered overrides everything, including an open handshake
        if (!pwr_ready && (state_q inside {[SETTLE:DN_ISSUE]})) begin
            state_d     = ERROR;
            spi_valid_d = 1'b0;
        end
    end
    assign stop_pend_d = ((state_d == UP_FETCH) || (state_d == UP_ISSUE)) && stop_eff;
    always_ff @(posedge clk72 or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            ph_q            <= 1'b0;
            stop_pend_q     <= 1'b0;
            tbl_addr_q      <= '0;
            spi_valid_q     <= 1'b0;
            spi_addr_q      <= '0;
            spi_wdata_q     <= '0;
            pwr_enable_q    <= 1'b0;
            sensor_active_q <= 1'b0;
            busy_q          <= 1'b0;
            seq_error_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            ph_q            <= ph_d;
            stop_pend_q     <= stop_pend_d;
            tbl_addr_q      <= tbl_addr_d;
            spi_valid_q     <= spi_valid_d;
            spi_addr_q      <= spi_addr_d;
            spi_wdata_q     <= spi_wdata_d;
            pwr_enable_q    <= state_d inside {[PWR_UP:DN_ISSUE]};
            sensor_active_q <= state_d == ACTIVE;
            busy_q          <= !(state_d inside {IDLE, ACTIVE, ERROR});
            seq_error_q     <= state_d == ERROR;
        end
    end
    assign bus.tbl_addr  = tbl_addr_q;
    assign bus.spi_valid = spi_valid_q;
    assign bus.spi_addr  = spi_addr_q;
    assign bus.spi_wdata = spi_wdata_q;
    assign pwr_enable    = pwr_enable_q;
    assign sensor_active = sensor_active_q;
    assign busy          = busy_q;
    assign seq_error     = seq_error_q;
    assign state         = state_q;
endmodule

// File: tb/tb_sensor_seq_ctl.sv
// tb_sensor_seq_ctl: directed bring-up/tear-down scenarios with a queued scoreboard on the SPI write port.
module tb_sensor_seq_ctl;
    logic clk72 = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, pwr_ready = 1'b0;
    logic pwr_enable, sensor_active, busy, seq_error;
    logic [3:0] state;
    int n_vec = 0, n_err = 0;
    typedef struct {logic [8:0] addr; logic [15:0] wdata; int stall;} exp_t;
    exp_t exp_q[$];
    logic [25:0] mem [256];
    sensor_seq_if #(.TBL_AW(8)) bus ();
    sensor_seq_ctl #(.TIMEOUT_CYCLES(100)) dut (
        .clk72(clk72), .reset(reset), .start(start), .stop(stop),
        .pwr_enable(pwr_enable), .pwr_ready(pwr_ready), .bus(bus),
        .sensor_active(sensor_active), .busy(busy), .seq_error(seq_error), .state(state)
    );
    always #5 clk72 = !clk72;
    always @(posedge clk72) bus.tbl_data <= mem[bus.tbl_addr];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic push(input logic [8:0] a, input logic [15:0] w, input int s);
        exp_t e;
        e.addr = a; e.wdata = w; e.stall = s;
        exp_q.push_back(e);
    endtask
    task automatic cyc(input int n);
        repeat (n) @(negedge clk72);
    endtask
    task automatic pulse_start();
        start = 1'b1; cyc(1); start = 1'b0;
    endtask
    task automatic pulse_stop();
        stop = 1'b1; cyc(1); stop = 1'b0;
    endtask
    task automatic wait_st(input logic [3:0] s, input int budget, input string nm);
        int n = 0;
        while (state !== s && n < budget) begin cyc(1); n++; end
        chk(nm, state, s);
    endtask
    // SPI slave + scoreboard monitor
    initial begin
        int vcyc = 0;
        logic [8:0] la;
        logic [15:0] lw;
        logic stable;
        exp_t e;
        bus.spi_ready = 1'b0;
        forever begin
            @(negedge clk72);
            if (reset || !bus.spi_valid) begin
                bus.spi_ready = 1'b0;
                vcyc = 0;
            end else begin
                if (vcyc == 0) begin la = bus.spi_addr; lw = bus.spi_wdata; stable = 1'b1; end
                else if (bus.spi_addr !== la || bus.spi_wdata !== lw) stable = 1'b0;
                vcyc++;
                if (exp_q.size() == 0) begin
                    if (vcyc == 1) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_write: got addr %0h data %0h, expected none", bus.spi_addr, bus.spi_wdata);
                    end
                    bus.spi_ready = 1'b1;
                end else if (vcyc <= exp_q[0].stall) bus.spi_ready = 1'b0;
                else begin
                    e = exp_q.pop_front();
                    chk("spi_addr", bus.spi_addr, e.addr);
                    chk("spi_wdata", bus.spi_wdata, e.wdata);
                    if (e.stall > 0) begin
                        chk("hold_cycles", vcyc, e.stall + 1);
                        chk("hold_stable", stable, 1);
                    end
                    bus.spi_ready = 1'b1;
                end
            end
        end
    end
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 26'h2000000;
        mem[0] = {1'b0, 9'h010, 16'h1111};
        mem[1] = {1'b0, 9'h021, 16'h2222};
        mem[2] = {1'b0, 9'h132, 16'h3333};
        mem[3] = {1'b1, 9'h000, 16'h0000};
        mem[128] = {1'b0, 9'h0A0, 16'hDEAD};
        mem[129] = {1'b0, 9'h0A1, 16'hBEEF};
        mem[130] = {1'b1, 9'h000, 16'h0000};
        cyc(2);
        chk("rst_state", state, 0);
        chk("rst_pwr_enable", pwr_enable, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        cyc(2);
        start = 1'b1; stop = 1'b1; cyc(1); start = 1'b0; stop = 1'b0;
        cyc(1);
        chk("start_stop_idle", state, 0);
        chk("start_stop_pwr", pwr_enable, 0);
        // bring-up with immediate spi_ready
        push(9'h010, 16'h1111, 0); push(9'h021, 16'h2222, 0); push(9'h132, 16'h3333, 0);
        pulse_start();
        chk("pwr_up_state", state, 1);
        chk("pwr_up_enable", pwr_enable, 1);
        chk("pwr_up_busy", busy, 1);
        cyc(49);
        pwr_ready = 1'b1;
        cyc(1);
        chk("settle_enter", state, 2);
        cyc(7199);
        chk("settle_last", state, 2);
        cyc(1);
        chk("settle_done", state, 3);
        wait_st(4'd5, 100, "up_to_active");
        chk("active_flag", sensor_active, 1);
        chk("active_busy", busy, 0);
        chk("up_all_written", exp_q.size(), 0);
        // power-down from ACTIVE
        push(9'h0A0, 16'hDEAD, 0); push(9'h0A1, 16'hBEEF, 0);
        pulse_stop();
        chk("active_cleared", sensor_active, 0);
        wait_st(4'd8, 100, "dn_to_pwr_dn");
        chk("pwr_dn_enable", pwr_enable, 0);
        chk("dn_all_written", exp_q.size(), 0);
        pwr_ready = 1'b0;
        cyc(1);
        chk("pwr_dn_idle", state, 0);
        // bring-up with write 2 stalled 20 cycles
        push(9'h010, 16'h1111, 0); push(9'h021, 16'h2222, 20); push(9'h132, 16'h3333, 0);
        pulse_start();
        cyc(3);
        pwr_ready = 1'b1;
        wait_st(4'd5, 7400, "stall_to_active");
        chk("stall_all_written", exp_q.size(), 0);
        // power loss while ACTIVE
        pwr_ready = 1'b0;
        cyc(1);
        chk("drop_error", state, 9);
        chk("drop_seq_error", seq_error, 1);
        chk("drop_pwr_enable", pwr_enable, 0);
        cyc(5);
        chk("error_sticky", seq_error, 1);
        pulse_start();
        chk("error_restart", state, 1);
        chk("error_cleared", seq_error, 0);
        // stop during UP_ISSUE of write 1
        push(9'h010, 16'h1111, 5);
        cyc(2);
        pwr_ready = 1'b1;
        wait_st(4'd4, 7400, "to_up_issue");
        push(9'h0A0, 16'hDEAD, 0); push(9'h0A1, 16'hBEEF, 0);
        pulse_stop();
        wait_st(4'd8, 200, "stop_to_pwr_dn");
        chk("stop_pwr_enable", pwr_enable, 0);
        chk("stop_all_written", exp_q.size(), 0);
        pwr_ready = 1'b0;
        cyc(1);
        chk("stop_idle", state, 0);
        // asynchronous reset in UP_ISSUE
        push(9'h010, 16'h1111, 1000);
        pulse_start();
        pwr_ready = 1'b1;
        wait_st(4'd4, 7400, "to_up_issue_rst");
        chk("pre_rst_valid", bus.spi_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_state", state, 0);
        chk("arst_pwr_enable", pwr_enable, 0);
        chk("arst_spi_valid", bus.spi_valid, 0);
        chk("arst_spi_addr", bus.spi_addr, 0);
        chk("arst_spi_wdata", bus.spi_wdata, 0);
        chk("arst_tbl_addr", bus.tbl_addr, 0);
        chk("arst_flags", {sensor_active, busy, seq_error}, 0);
        exp_q.delete();
        pwr_ready = 1'b0;
        cyc(2);
        reset = 1'b0;
        cyc(1);
        // pwr_ready never rises
        pulse_start();
`ifdef SENSOR_SEQ_TIMEOUT_EN
        cyc(99);
        chk("timeout_wait", state, 1);
        cyc(1);
        chk("timeout_error", state, 9);
        chk("timeout_seq_error", seq_error, 1);
`else
        cyc(1000);
        chk("no_timeout", state, 1);
        pulse_stop();
        chk("pwr_up_stop", state, 8);
        cyc(1);
        chk("pwr_up_stop_idle", state, 0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sensor_seq_ctl.md
SENSOR_SEQ_CTL -- requirements
Module: sensor_seq_ctl

Interface
REQ-001 SHALL have parameter TBL_AW, 8, table address width.
REQ-002 SHALL have parameter UP_BASE, 0, table address of the first power-up (register upload) entry.
REQ-003 SHALL have parameter DN_BASE, 128, table address of the first power-down entry.
REQ-004 SHALL have parameter SETTLE_CYCLES, 7200, clk72 cycles waited after pwr_ready rises before the first SPI write (100 us).
REQ-005 SHALL have parameter TIMEOUT_CYCLES, 720000, clk72 cycles allowed for pwr_ready to rise (10 ms).
REQ-006 SHALL have port clk72  input  1  sole clock, all logic on its rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have ports start / stop  input  1  single-cycle requests to bring the sensor up / down.
REQ-009 SHALL have port pwr_enable  output  1  enable to the sensor power manager.
REQ-010 SHALL have port pwr_ready  input  1  power manager reports rails, clock and reset_n sequenced up.
REQ-011 SHALL have ports tbl_addr  output  TBL_AW and tbl_data  input  26  sequence table, read data valid 1 cycle after tbl_addr; bit25 end, [24:16] register address, [15:0] value.
REQ-012 SHALL have ports spi_valid  output  1, spi_addr  output  9, spi_wdata  output  16, spi_ready  input  1  register-write request to the SPI master.
REQ-013 SHALL have ports sensor_active  output  1, busy  output  1, seq_error  output  1, state  output  4  status.

Function
REQ-014 SHALL implement states IDLE, PWR_UP, SETTLE, UP_FETCH, UP_ISSUE, ACTIVE, DN_FETCH, DN_ISSUE, PWR_DN, ERROR; state output carries the encoding 0..9 in that order.
REQ-015 IDLE: start -> PWR_UP, pwr_enable=1; stop ignored.
REQ-016 PWR_UP: pwr_ready=1 -> SETTLE, counter loaded with SETTLE_CYCLES-1; SETTLE at counter 0 -> UP_FETCH with tbl_addr=UP_BASE.
REQ-017 *_FETCH SHALL take exactly 2 cycles (address, data); entry with end=1 leaves UP -> ACTIVE, DN -> PWR_DN, no SPI write issued.
REQ-018 *_ISSUE SHALL hold spi_valid=1 with stable addr/wdata until the cycle spi_ready=1, then increment tbl_addr (wraps modulo 2^TBL_AW) and return to *_FETCH.
REQ-019 ACTIVE: sensor_active=1; stop -> DN_FETCH with tbl_addr=DN_BASE.
REQ-020 PWR_DN: pwr_enable=0; pwr_ready=0 -> IDLE.
REQ-021 stop during PWR_UP/SETTLE -> PWR_DN directly; during UP_FETCH/UP_ISSUE -> latched, current SPI handshake completes, then DN_FETCH.
REQ-022 start and stop in the same cycle: stop wins; start in any non-IDLE state ignored.
REQ-023 pwr_ready falling in SETTLE, UP_*, ACTIVE or DN_* -> ERROR, no handshake abandoned mid-transfer except spi_valid dropped immediately since sensor is unpowered.
REQ-024 ERROR: pwr_enable=0, seq_error=1 (sticky); start -> clear seq_error, PWR_UP.
REQ-025 busy=1 in every state except IDLE, ACTIVE, ERROR.
REQ-026 Outputs SHALL be registered; SPI write count per sequence is unbounded except by table wrap.

Reset
REQ-027 reset SHALL force IDLE asynchronously: pwr_enable=0, spi_valid=0, spi_addr=0, spi_wdata=0, tbl_addr=0, sensor_active=0, busy=0, seq_error=0, state=0, counters 0, latched stop cleared.

Configuration
REQ-028 With SENSOR_SEQ_TIMEOUT_EN defined, PWR_UP SHALL count cycles and enter ERROR if pwr_ready not seen within TIMEOUT_CYCLES.
REQ-029 Without SENSOR_SEQ_TIMEOUT_EN, PWR_UP SHALL wait indefinitely and the timeout counter SHALL not exist.

Verification
REQ-030 start, pwr_ready 50 cycles later, table UP_BASE 3 writes + end, spi_ready immediate -> 3 handshakes in order after 7200 settle cycles, then sensor_active=1.
REQ-031 spi_ready held low 20 cycles on write 2 -> spi_valid/addr/wdata stable for 21 cycles, no write skipped or repeated.
REQ-032 stop during UP_ISSUE of write 1 -> write 1 completes, DN table (2 writes) issued, pwr_enable=0, IDLE after pwr_ready=0.
REQ-033 start+stop same cycle in IDLE -> stays IDLE; pwr_ready drop in ACTIVE -> ERROR, seq_error=1, pwr_enable=0 next cycle.
REQ-034 With SENSOR_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=100, pwr_ready never rises -> ERROR at cycle 100; without macro still PWR_UP at cycle 1000.
REQ-035 reset asserted mid-UP_ISSUE -> all outputs at reset values without a clock edge.
